// File: rtl/rf_write_arbiter.sv
// Two-requester round-robin write arbiter driving a single register-file write port.
// Define RF_WRITE_ARBITER_SWEEP_EN to add the sweep engine that fills every register.
module rf_write_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              req_b,
    input  logic [ADDR_W-1:0] adr_a,
    input  logic [ADDR_W-1:0] adr_b,
    input  logic [DATA_W-1:0] dat_a,
    input  logic [DATA_W-1:0] dat_b,
    output logic              gnt_a,
    output logic              gnt_b,
    input  logic              sweep_start,
    input  logic [DATA_W-1:0] sweep_val,
    output logic              busy,
    output logic              done,
    output logic              we,
    output logic [ADDR_W-1:0] W_Adr,
    output logic [DATA_W-1:0] W
);
    logic              elig_a, elig_b, pick_a, pick_b;
    logic              last_b_q, last_b_d, arb_last_b;
    logic              gnt_a_d, gnt_b_d, we_d;
    logic [ADDR_W-1:0] w_adr_d, arb_w_adr;
    logic [DATA_W-1:0] w_d, arb_w;

    // A requester granted in this cycle sits out the next edge.
    assign elig_a = req_a & ~gnt_a;
    assign elig_b = req_b & ~gnt_b;
    // last_b_q high means B won most recently, so A takes a tie.
    assign pick_a = elig_a & (~elig_b | last_b_q);
    assign pick_b = elig_b & ~pick_a;

    always_comb begin
        arb_w_adr  = W_Adr;
        arb_w      = W;
        arb_last_b = last_b_q;
        if (pick_a) begin
            arb_w_adr  = adr_a;
            arb_w      = dat_a;
            arb_last_b = 1'b0;
        end else if (pick_b) begin
            arb_w_adr  = adr_b;
            arb_w      = dat_b;
            arb_last_b = 1'b1;
        end
    end

`ifdef RF_WRITE_ARBITER_SWEEP_EN
    localparam logic [1:0] StArb   = 2'd0;
    localparam logic [1:0] StSweep = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;
    localparam logic [ADDR_W-1:0] LastAdr = {ADDR_W{1'b1}};

    logic [1:0] state_q, state_d;
    logic       busy_d, done_d;

    always_comb begin
        state_d  = state_q;
        gnt_a_d  = 1'b0;
        gnt_b_d  = 1'b0;
        we_d     = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        w_adr_d  = W_Adr;
        w_d      = W;
        last_b_d = last_b_q;
        case (state_q)
            StArb: begin
                if (sweep_start) begin
                    // W holds the captured fill value for the whole pass.
                    state_d = StSweep;
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                    w_adr_d = '0;
                    w_d     = sweep_val;
                end else begin
                    gnt_a_d  = pick_a;
                    gnt_b_d  = pick_b;
                    we_d     = pick_a | pick_b;
                    w_adr_d  = arb_w_adr;
                    w_d      = arb_w;
                    last_b_d = arb_last_b;
                end
            end
            StSweep: begin
                if (W_Adr == LastAdr) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                    w_adr_d = W_Adr + 1'b1;
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StArb;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end
`else
    logic unused_sweep;
    assign unused_sweep = ^{sweep_start, sweep_val};

    assign gnt_a_d  = pick_a;
    assign gnt_b_d  = pick_b;
    assign we_d     = pick_a | pick_b;
    assign w_adr_d  = arb_w_adr;
    assign w_d      = arb_w;
    assign last_b_d = arb_last_b;
    assign busy     = 1'b0;
    assign done     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            we       <= 1'b0;
            W_Adr    <= '0;
            W        <= '0;
            last_b_q <= 1'b1;
        end else begin
            gnt_a    <= gnt_a_d;
            gnt_b    <= gnt_b_d;
            we       <= we_d;
            W_Adr    <= w_adr_d;
            W        <= w_d;
            last_b_q <= last_b_d;
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter; sweep scenarios run only when
// RF_WRITE_ARBITER_SWEEP_EN is defined, the sweep-disabled scenario otherwise.
module tb_rf_write_arbiter;
    logic        clk;
    logic        reset;
    logic        req_a, req_b;
    logic [2:0]  adr_a, adr_b;
    logic [15:0] dat_a, dat_b;
    logic        gnt_a, gnt_b;
    logic        sweep_start;
    logic [15:0] sweep_val;
    logic        busy, done, we;
    logic [2:0]  W_Adr;
    logic [15:0] W;

    int nvec  = 0;
    int nfail = 0;

    rf_write_arbiter #(
        .DATA_W(16),
        .ADDR_W(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_a      (req_a),
        .req_b      (req_b),
        .adr_a      (adr_a),
        .adr_b      (adr_b),
        .dat_a      (dat_a),
        .dat_b      (dat_b),
        .gnt_a      (gnt_a),
        .gnt_b      (gnt_b),
        .sweep_start(sweep_start),
        .sweep_val  (sweep_val),
        .busy       (busy),
        .done       (done),
        .we         (we),
        .W_Adr      (W_Adr),
        .W          (W)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset       = 1'b0;
        req_a       = 1'b0;
        req_b       = 1'b0;
        adr_a       = '0;
        adr_b       = '0;
        dat_a       = '0;
        dat_b       = '0;
        sweep_start = 1'b0;
        sweep_val   = '0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        nvec++;
        if ({gnt_a, gnt_b, we, busy, done} !== 5'b0 || W_Adr !== 3'd0 || W !== 16'h0) begin
            nfail++;
            $display("FAIL reset: gnt_a=%b gnt_b=%b we=%b busy=%b done=%b W_Adr=%0d W=%h, want all 0",
                     gnt_a, gnt_b, we, busy, done, W_Adr, W);
        end
    endtask

    task automatic test_single_a();
        apply_reset();
        reset = 1'b1;
        req_a = 1'b1;
        adr_a = 3'd2;
        dat_a = 16'hFFFD;
        for (int i = 0; i < 3; i++) begin
            tick();
            nvec++;
            if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || we !== 1'b1 || W_Adr !== 3'd2 || W !== 16'hFFFD) begin
                nfail++;
                $display("FAIL single_a_grant[%0d]: gnt_a=%b gnt_b=%b we=%b W_Adr=%0d W=%h, want 1 0 1 2 fffd",
                         i, gnt_a, gnt_b, we, W_Adr, W);
            end
            tick();
            nvec++;
            if (gnt_a !== 1'b0 || gnt_b !== 1'b0 || we !== 1'b0 || W_Adr !== 3'd2 || W !== 16'hFFFD) begin
                nfail++;
                $display("FAIL single_a_gap[%0d]: gnt_a=%b gnt_b=%b we=%b W_Adr=%0d W=%h, want 0 0 0 2 fffd",
                         i, gnt_a, gnt_b, we, W_Adr, W);
            end
        end
    endtask

    task automatic test_tie();
        logic exp_a;
        apply_reset();
        reset = 1'b1;
        req_a = 1'b1;
        req_b = 1'b1;
        adr_a = 3'd1;
        dat_a = 16'h1111;
        adr_b = 3'd6;
        dat_b = 16'h2222;
        exp_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            nvec++;
            if (gnt_a !== exp_a || gnt_b !== ~exp_a || we !== 1'b1 ||
                W_Adr !== (exp_a ? 3'd1 : 3'd6) || W !== (exp_a ? 16'h1111 : 16'h2222)) begin
                nfail++;
                $display("FAIL tie[%0d]: gnt_a=%b gnt_b=%b we=%b W_Adr=%0d W=%h, want gnt_a=%b gnt_b=%b",
                         i, gnt_a, gnt_b, we, W_Adr, W, exp_a, ~exp_a);
            end
            exp_a = ~exp_a;
        end
    endtask

    task automatic test_pointer();
        apply_reset();
        reset = 1'b1;
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        tick();
        req_a = 1'b1;
        req_b = 1'b1;
        adr_b = 3'd7;
        dat_b = 16'h7777;
        tick();
        nvec++;
        if (gnt_a !== 1'b0 || gnt_b !== 1'b1 || we !== 1'b1 || W_Adr !== 3'd7 || W !== 16'h7777) begin
            nfail++;
            $display("FAIL pointer_tie: gnt_a=%b gnt_b=%b we=%b W_Adr=%0d W=%h, want 0 1 1 7 7777",
                     gnt_a, gnt_b, we, W_Adr, W);
        end
    endtask

`ifdef RF_WRITE_ARBITER_SWEEP_EN
    task automatic test_sweep();
        apply_reset();
        reset       = 1'b1;
        sweep_start = 1'b1;
        sweep_val   = 16'h00A5;
        req_b       = 1'b1;
        adr_b       = 3'd5;
        dat_b       = 16'hBEEF;
        for (int i = 0; i < 8; i++) begin
            tick();
            sweep_start = 1'b0;
            nvec++;
            if (we !== 1'b1 || W_Adr !== 3'(i) || W !== 16'h00A5 || busy !== 1'b1 ||
                gnt_a !== 1'b0 || gnt_b !== 1'b0 || done !== 1'b0) begin
                nfail++;
                $display("FAIL sweep_cycle[%0d]: we=%b W_Adr=%0d W=%h busy=%b gnt_b=%b done=%b, want 1 %0d 00a5 1 0 0",
                         i, we, W_Adr, W, busy, gnt_b, done, i);
            end
        end
        tick();
        nvec++;
        if (done !== 1'b1 || we !== 1'b0 || busy !== 1'b0 || gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
            nfail++;
            $display("FAIL sweep_done: done=%b we=%b busy=%b gnt_b=%b, want 1 0 0 0", done, we, busy, gnt_b);
        end
        tick();
        nvec++;
        if (done !== 1'b0 || we !== 1'b0 || gnt_b !== 1'b0) begin
            nfail++;
            $display("FAIL sweep_back_to_arb: done=%b we=%b gnt_b=%b, want 0 0 0", done, we, gnt_b);
        end
        tick();
        nvec++;
        if (gnt_b !== 1'b1 || gnt_a !== 1'b0 || we !== 1'b1 || W_Adr !== 3'd5 || W !== 16'hBEEF) begin
            nfail++;
            $display("FAIL sweep_late_grant: gnt_b=%b we=%b W_Adr=%0d W=%h, want 1 1 5 beef",
                     gnt_b, we, W_Adr, W);
        end
    endtask

    task automatic test_sweep_reset();
        int bad;
        apply_reset();
        reset       = 1'b1;
        sweep_start = 1'b1;
        sweep_val   = 16'h3C3C;
        for (int i = 0; i < 4; i++) begin
            tick();
            sweep_start = 1'b0;
        end
        nvec++;
        if (we !== 1'b1 || W_Adr !== 3'd3) begin
            nfail++;
            $display("FAIL sweep_reset_pre: we=%b W_Adr=%0d, want 1 3", we, W_Adr);
        end
        reset = 1'b0;
        tick();
        nvec++;
        if ({we, busy, done} !== 3'b0 || W_Adr !== 3'd0 || W !== 16'h0) begin
            nfail++;
            $display("FAIL sweep_reset_abort: we=%b busy=%b done=%b W_Adr=%0d W=%h, want 0 0 0 0 0000",
                     we, busy, done, W_Adr, W);
        end
        reset = 1'b1;
        bad   = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
        end
        nvec++;
        if (bad !== 0) begin
            nfail++;
            $display("FAIL sweep_reset_no_resume: %0d cycles with we/done/busy set, want 0", bad);
        end
    endtask

    task automatic test_sweep_ignore();
        int writes, dones, badadr;
        apply_reset();
        reset       = 1'b1;
        sweep_start = 1'b1;
        sweep_val   = 16'h5A5A;
        writes      = 0;
        dones       = 0;
        badadr      = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            sweep_start = (i == 3) || (i == 9);
            if (we === 1'b1) begin
                if (W_Adr !== 3'(writes) || W !== 16'h5A5A) badadr++;
                writes++;
            end
            if (done === 1'b1) dones++;
        end
        nvec++;
        if (writes !== 8 || badadr !== 0) begin
            nfail++;
            $display("FAIL sweep_ignore_writes: writes=%0d bad=%0d, want 8 0", writes, badadr);
        end
        nvec++;
        if (dones !== 1) begin
            nfail++;
            $display("FAIL sweep_ignore_done: pulses=%0d, want 1", dones);
        end
    endtask
`else
    task automatic test_no_sweep();
        int flagged, grants;
        apply_reset();
        reset       = 1'b1;
        sweep_start = 1'b1;
        sweep_val   = 16'h1234;
        req_a       = 1'b1;
        adr_a       = 3'd4;
        dat_a       = 16'h0042;
        tick();
        nvec++;
        if (gnt_a !== 1'b1 || we !== 1'b1 || W_Adr !== 3'd4 || W !== 16'h0042 ||
            busy !== 1'b0 || done !== 1'b0) begin
            nfail++;
            $display("FAIL no_sweep_grant: gnt_a=%b we=%b W_Adr=%0d W=%h busy=%b done=%b, want 1 1 4 0042 0 0",
                     gnt_a, we, W_Adr, W, busy, done);
        end
        flagged = 0;
        grants  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0) flagged++;
            if (gnt_a === 1'b1) grants++;
        end
        nvec++;
        if (flagged !== 0 || grants !== 5) begin
            nfail++;
            $display("FAIL no_sweep_idle: busy/done cycles=%0d grants=%0d, want 0 5", flagged, grants);
        end
    endtask
`endif

    initial begin
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_a();
        test_tie();
        test_pointer();
`ifdef RF_WRITE_ARBITER_SWEEP_EN
        test_sweep();
        test_sweep_reset();
        test_sweep_ignore();
`else
        test_no_sweep();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
